// File: rtl/serial_seq_gen.sv
// serial_seq_gen: MSB-first serial pattern transmitter with repeat passes and inter-pass gap.
module serial_seq_gen #(
   parameter int WIDTH = 16,
   parameter int GAP = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [WIDTH-1:0]       pattern,
   input  logic [$clog2(WIDTH):0] len,
   input  logic [3:0]             reps,
   input  logic                   start,
   input  logic                   abort,
   output logic                   I,
   output logic                   valid,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   localparam int LW = $clog2(WIDTH) + 1;
   localparam int IW = $clog2(WIDTH);
   localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
   state_t state, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [LW-1:0] len_q, len_d;
   logic [3:0] reps_q, reps_d, pass_q, pass_d;
   logic [IW-1:0] idx_q, idx_d, first_idx;
   logic [GW-1:0] gap_q, gap_d;
   logic i_d, valid_d, done_d, err_d, legal;
   // Freshly loaded values are visible in the same cycle so load+start sends them.
   assign pat_d = (state == S_IDLE && load) ? pattern : pat_q;
   assign len_d = (state == S_IDLE && load) ? len : len_q;
   assign reps_d = (state == S_IDLE && load) ? reps : reps_q;
   assign legal = len_d != '0 && len_d <= LW'(WIDTH);
   assign first_idx = IW'(len_d - 1'b1);
   assign busy = state != S_IDLE;
   always_comb begin
      state_d = state;
      idx_d = idx_q;
      pass_d = pass_q;
      gap_d = gap_q;
      i_d = 1'b0;
      valid_d = 1'b0;
      done_d = 1'b0;
      err_d = 1'b0;
      case (state)
         S_IDLE:
            if (start && !abort) begin
               if (legal) begin
                  state_d = S_SEND;
                  idx_d = first_idx;
                  pass_d = '0;
                  i_d = pat_d[first_idx];
                  valid_d = 1'b1;
               end else
                  err_d = 1'b1;
            end
         S_SEND:
            if (abort)
               state_d = S_IDLE;
            else if (idx_q != '0) begin
               idx_d = idx_q - 1'b1;
               i_d = pat_q[idx_d];
               valid_d = 1'b1;
            end else if (pass_q == reps_q) begin
               state_d = S_IDLE;
               done_d = 1'b1;
            end else begin
               pass_d = pass_q + 4'd1;
               if (GAP > 0) begin
                  state_d = S_GAP;
                  gap_d = GW'(GAP - 1);
               end else begin
                  idx_d = first_idx;
                  i_d = pat_q[first_idx];
                  valid_d = 1'b1;
               end
            end
         S_GAP:
            if (abort)
               state_d = S_IDLE;
            else if (gap_q != '0)
               gap_d = gap_q - 1'b1;
            else begin
               state_d = S_SEND;
               idx_d = first_idx;
               i_d = pat_q[first_idx];
               valid_d = 1'b1;
            end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= S_IDLE;
         pat_q <= '0;
         len_q <= '0;
         reps_q <= '0;
         pass_q <= '0;
         idx_q <= '0;
         gap_q <= '0;
         I <= 1'b0;
         valid <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         state <= state_d;
         pat_q <= pat_d;
         len_q <= len_d;
         reps_q <= reps_d;
         pass_q <= pass_d;
         idx_q <= idx_d;
         gap_q <= gap_d;
         I <= i_d;
         valid <= valid_d;
         done <= done_d;
         err <= err_d;
      end
endmodule
